alarm_bank: RTL

Parametrised multi-channel alarm scheduler that replaces the per-alarm broadcast control used in the current clock top. CH independent alarms compare against seconds-of-day from the watch core. Each channel has its own ring/snooze state machine. Global off/snooze strobes act only on the highest-priority ringing channel, not on all channels. The block also drives the display-mode select for the VGA mux, so the alarm banner appears while any channel rings.

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/alarm_chan.sv | 112 +++++++++++
 rtl/alarm_bank.sv | 83 ++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm scheduler.
// The optional auto-snooze behaviour is selected with ALARM_BANK_AUTO_SNOOZE_EN.
package alarm_pkg;

  localparam int SEC_PER_DAY = 86400;
  localparam int SEC_W       = 17;

  typedef enum logic [1:0] {
    DISABLED,
    ARMED,
    RINGING,
    SNOOZED
  } alarm_state_t;

  localparam logic [1:0] SHOW_DEFAULT = 2'd0;
  localparam logic [1:0] SHOW_TIME    = 2'd1;
  localparam logic [1:0] SHOW_ALARM   = 2'd2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_chan.sv
// One alarm channel: configuration registers plus the ring/snooze state machine.
// Ring timeout behaviour depends on ALARM_BANK_AUTO_SNOOZE_EN.
module alarm_chan
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 10,
  parameter int SNOOZE_SEC = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [SEC_W-1:0] cur_sec_i,
  input  logic             wr_i,
  input  logic [SEC_W-1:0] set_sec_i,
  input  logic             set_en_i,
  input  logic             off_i,
  input  logic             snooze_i,
  output logic             ring_o
);

  localparam int CNT_W = $clog2(max2(RING_SEC, SNOOZE_SEC) + 1);
  localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

  alarm_state_t     state;
  logic [SEC_W-1:0] alarm_sec;
  logic [CNT_W-1:0] ring_cnt;
  logic [SNZ_W-1:0] snz_num;
  logic             snz_ok;

  assign snz_ok = (snz_num < SNZ_MAX);
  assign ring_o = (state == RINGING);

  // NOTE: every register here is written with <= so all channels see the
  // pre-edge value of each other's state, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= DISABLED;
      alarm_sec <= '0;
      ring_cnt  <= '0;
      snz_num   <= '0;
    end else if (wr_i) begin
      // A config write overrides any ring or snooze in progress.
      alarm_sec <= set_sec_i;
      state     <= set_en_i ? ARMED : DISABLED;
      ring_cnt  <= '0;
      snz_num   <= '0;
    end else begin
      case (state)
        ARMED: begin
          if (tick_i && (cur_sec_i == alarm_sec)) begin
            state    <= RINGING;
            ring_cnt <= RING_LD;
          end
        end
        RINGING: begin
          if (off_i) begin
            state    <= ARMED;
            ring_cnt <= '0;
            snz_num  <= '0;
          end else if (snooze_i) begin
            if (snz_ok) begin
              state    <= SNOOZED;
              ring_cnt <= SNOOZE_LD;
              snz_num  <= snz_num + SNZ_W'(1);
            end else begin
              state    <= ARMED;
              ring_cnt <= '0;
              snz_num  <= '0;
            end
          end else if (tick_i) begin
            if (ring_cnt == CNT_W'(1)) begin
`ifdef ALARM_BANK_AUTO_SNOOZE_EN
              if (snz_ok) begin
                state    <= SNOOZED;
                ring_cnt <= SNOOZE_LD;
                snz_num  <= snz_num + SNZ_W'(1);
              end else begin
                state    <= ARMED;
                ring_cnt <= '0;
                snz_num  <= '0;
              end
`else
              state    <= ARMED;
              ring_cnt <= '0;
              snz_num  <= '0;
`endif
            end else begin
              ring_cnt <= ring_cnt - CNT_W'(1);
            end
          end
        end
        SNOOZED: begin
          if (tick_i) begin
            if (ring_cnt == CNT_W'(1)) begin
              state    <= RINGING;
              ring_cnt <= RING_LD;
            end else begin
              ring_cnt <= ring_cnt - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// CH-channel alarm scheduler: channel array, lowest-index priority encoder,
// strobe routing to the active channel and VGA show-mode select.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int CH         = 7,
  parameter int RING_SEC   = 10,
  parameter int SNOOZE_SEC = 5,
  parameter int MAX_SNOOZE = 3,
  localparam int IDX_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [SEC_W-1:0] cur_sec_i,
  input  logic             set_wr_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic [SEC_W-1:0] set_sec_i,
  input  logic             set_en_i,
  input  logic             off_stb_i,
  input  logic             snooze_stb_i,
  output logic [CH-1:0]    alarm_o,
  output logic             active_vld_o,
  output logic [IDX_W-1:0] active_idx_o,
  output logic [1:0]       show_mode_o
);

  logic             wr_ok;
  logic             enc_vld;
  logic [IDX_W-1:0] enc_idx;

  // Out-of-range index or time-of-day drops the whole write.
  assign wr_ok = set_wr_i && (32'(set_idx_i) < 32'(CH))
                          && (32'(set_sec_i) < 32'(SEC_PER_DAY));

  for (genvar i = 0; i < CH; i++) begin : g_chan
    logic sel;
    assign sel = active_vld_o && (active_idx_o == IDX_W'(i));

    alarm_chan #(
      .RING_SEC  (RING_SEC),
      .SNOOZE_SEC(SNOOZE_SEC),
      .MAX_SNOOZE(MAX_SNOOZE)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick_i   (tick_i),
      .cur_sec_i(cur_sec_i),
      .wr_i     (wr_ok && (set_idx_i == IDX_W'(i))),
      .set_sec_i(set_sec_i),
      .set_en_i (set_en_i),
      .off_i    (off_stb_i && sel),
      .snooze_i (snooze_stb_i && sel),
      .ring_o   (alarm_o[i])
    );
  end

  // NOTE: both outputs get a default before the loop so no latch is inferred
  // when no channel is ringing.
  always_comb begin
    enc_vld = 1'b0;
    enc_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (alarm_o[i]) begin
        enc_vld = 1'b1;
        enc_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_vld_o <= 1'b0;
      active_idx_o <= '0;
      show_mode_o  <= SHOW_TIME;
    end else begin
      active_vld_o <= enc_vld;
      active_idx_o <= enc_idx;
      show_mode_o  <= enc_vld ? SHOW_ALARM : SHOW_TIME;
    end
  end

endmodule
